// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-port (read-only) and the D-port.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed D-over-I priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_busy,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_read,
  input  logic                  d_write,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_busy,
  output logic [ADDR_WIDTH-1:0] dn_addr,
  output logic [DATA_WIDTH-1:0] dn_wdata,
  output logic                  dn_read,
  output logic                  dn_write,
  input  logic [DATA_WIDTH-1:0] dn_rdata,
  input  logic                  dn_ack,
  output logic                  owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic                  i_req;
  logic                  d_req;
  logic                  grant;
  logic                  grant_d;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign grant = (state == IDLE) && (i_req || d_req);

`ifdef ARB_ROUND_ROBIN_EN
  // rr=1 favours the D-port on the next contended grant
  logic rr;

  assign grant_d = d_req && (!i_req || rr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr <= 1'b0;
    else if (grant)
      rr <= !grant_d;
  end
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (i_req || d_req) state_nx = XFER;
      XFER:    if (dn_ack) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    dn_read  = (state == XFER) && !wr_q;
    dn_write = (state == XFER) && wr_q;
    dn_addr  = (state == XFER) ? addr_q : '0;
    dn_wdata = (state == XFER) ? wdata_q : '0;
    i_busy   = i_req && !((state == DONE) && !owner);
    d_busy   = d_req && !((state == DONE) && owner);
  end

  // Request details are latched at grant so dn_* stay stable in XFER
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner   <= grant_d;
      wr_q    <= grant_d && d_write;
      addr_q  <= grant_d ? d_addr : i_addr;
      wdata_q <= grant_d ? d_wdata : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if ((state == XFER) && dn_ack && !wr_q) begin
      if (owner)
        d_rdata <= dn_rdata;
      else
        i_rdata <= dn_rdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] i_addr;
  logic        i_read;
  logic [31:0] i_rdata;
  logic        i_busy;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_rdata;
  logic        d_busy;
  logic [31:0] dn_addr;
  logic [31:0] dn_wdata;
  logic        dn_read;
  logic        dn_write;
  logic [31:0] dn_rdata;
  logic        dn_ack;
  logic        owner;

  int n_cmp;
  int n_err;

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_addr   (i_addr),
    .i_read   (i_read),
    .i_rdata  (i_rdata),
    .i_busy   (i_busy),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_rdata  (d_rdata),
    .d_busy   (d_busy),
    .dn_addr  (dn_addr),
    .dn_wdata (dn_wdata),
    .dn_read  (dn_read),
    .dn_write (dn_write),
    .dn_rdata (dn_rdata),
    .dn_ack   (dn_ack),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_own;

  initial begin
    reset    = 1'b1;
    i_addr   = '0;
    i_read   = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    dn_rdata = '0;
    dn_ack   = 1'b0;
    n_cmp    = 0;
    n_err    = 0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = 4'b1010;
`else
    exp_own = 4'b1111;
`endif

    #2;
    chk("rst_dn_read", dn_read, 0);
    chk("rst_dn_write", dn_write, 0);
    chk("rst_dn_addr", dn_addr, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_owner", owner, 0);
    chk("rst_busy", {i_busy, d_busy}, 0);
    step();
    reset = 1'b0;
    step();

    // Single read, ack in cycle 3
    i_read = 1'b1;
    i_addr = 32'h40;
    #1;
    chk("rd_c0_busy", i_busy, 1);
    chk("rd_c0_dn_read", dn_read, 0);
    step();
    chk("rd_c1_dn_read", dn_read, 1);
    chk("rd_c1_dn_addr", dn_addr, 32'h40);
    chk("rd_c1_owner", owner, 0);
    step();
    chk("rd_c2_dn_read", dn_read, 1);
    chk("rd_c2_busy", i_busy, 1);
    step();
    dn_ack   = 1'b1;
    dn_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_c3_dn_read", dn_read, 1);
    chk("rd_c3_busy", i_busy, 1);
    step();
    dn_ack = 1'b0;
    #1;
    chk("rd_c4_busy", i_busy, 0);
    chk("rd_c4_rdata", i_rdata, 32'hDEADBEEF);
    chk("rd_c4_dn", {dn_read, dn_write, dn_addr}, 0);
    step();
    i_read = 1'b0;
    #1;
    chk("rd_c5_busy", i_busy, 0);
    step();
    chk("rd_idle_dn_read", dn_read, 0);

    // Write, ack after 2 cycles
    d_write = 1'b1;
    d_addr  = 32'h100;
    d_wdata = 32'h12345678;
    #1;
    chk("wr_c0_busy", d_busy, 1);
    step();
    d_wdata = 32'hFFFFFFFF;
    d_addr  = 32'hFFF;
    #1;
    chk("wr_c1_dn_write", dn_write, 1);
    chk("wr_c1_dn_read", dn_read, 0);
    chk("wr_c1_addr", dn_addr, 32'h100);
    chk("wr_c1_wdata", dn_wdata, 32'h12345678);
    step();
    dn_ack   = 1'b1;
    dn_rdata = 32'hBAD0BAD0;
    #1;
    chk("wr_c2_wdata", dn_wdata, 32'h12345678);
    chk("wr_c2_busy", d_busy, 1);
    step();
    dn_ack = 1'b0;
    #1;
    chk("wr_c3_busy", d_busy, 0);
    chk("wr_c3_dn_write", dn_write, 0);
    chk("wr_c3_d_rdata", d_rdata, 0);
    chk("wr_c3_i_rdata", i_rdata, 32'hDEADBEEF);
    step();
    d_write = 1'b0;
    step();

    // Contention, zero-wait memory
    i_read = 1'b1;
    i_addr = 32'h10;
    d_read = 1'b1;
    d_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      step();
      dn_ack   = 1'b1;
      dn_rdata = 32'h1000 + k;
      #1;
      chk($sformatf("ct%0d_owner", k), owner, exp_own[k]);
      chk($sformatf("ct%0d_addr", k), dn_addr,
          exp_own[k] ? 32'h20 : 32'h10);
      chk($sformatf("ct%0d_dn_read", k), dn_read, 1);
      step();
      dn_ack = 1'b0;
      #1;
      chk($sformatf("ct%0d_busy", k), {i_busy, d_busy},
          exp_own[k] ? 2'b10 : 2'b01);
      if (exp_own[k])
        chk($sformatf("ct%0d_rdata", k), d_rdata, 32'h1000 + k);
      else
        chk($sformatf("ct%0d_rdata", k), i_rdata, 32'h1000 + k);
      step();
    end
    i_read = 1'b0;
    d_read = 1'b0;
    step();

    // Back-to-back write miss
    d_read = 1'b1;
    d_addr = 32'h200;
    step();
    dn_ack   = 1'b1;
    dn_rdata = 32'hA5A5A5A5;
    #1;
    chk("b2b_rd_addr", dn_addr, 32'h200);
    step();
    dn_ack = 1'b0;
    #1;
    chk("b2b_done_busy", d_busy, 0);
    chk("b2b_done_rdata", d_rdata, 32'hA5A5A5A5);
    step();
    d_read  = 1'b0;
    d_write = 1'b1;
    d_wdata = 32'h55AA55AA;
    #1;
    chk("b2b_idle_busy", d_busy, 1);
    step();
    chk("b2b_dn_write", dn_write, 1);
    chk("b2b_wr_addr", dn_addr, 32'h200);
    chk("b2b_wr_wdata", dn_wdata, 32'h55AA55AA);
    dn_ack = 1'b1;
    step();
    dn_ack = 1'b0;
    #1;
    chk("b2b_wr_busy", d_busy, 0);
    chk("b2b_wr_rdata", d_rdata, 32'hA5A5A5A5);
    step();
    d_write = 1'b0;
    step();

    // Withdrawal during XFER
    d_read = 1'b1;
    d_addr = 32'h300;
    step();
    d_read = 1'b0;
    #1;
    chk("wd_c1_dn_read", dn_read, 1);
    chk("wd_c1_busy", d_busy, 0);
    step();
    dn_ack   = 1'b1;
    dn_rdata = 32'h77;
    #1;
    chk("wd_c2_dn_read", dn_read, 1);
    chk("wd_c2_addr", dn_addr, 32'h300);
    step();
    dn_ack = 1'b0;
    #1;
    chk("wd_c3_busy", d_busy, 0);
    chk("wd_c3_rdata", d_rdata, 32'h77);
    chk("wd_c3_dn_read", dn_read, 0);
    step();
    i_read = 1'b1;
    i_addr = 32'h44;
    step();
    dn_ack   = 1'b1;
    dn_rdata = 32'h99;
    #1;
    chk("wd_next_addr", dn_addr, 32'h44);
    chk("wd_next_owner", owner, 0);
    step();
    dn_ack = 1'b0;
    #1;
    chk("wd_next_rdata", i_rdata, 32'h99);
    chk("wd_next_busy", i_busy, 0);
    step();
    i_read = 1'b0;
    step();

    // Reset mid-XFER, then late ack
    i_read = 1'b1;
    i_addr = 32'h80;
    step();
    chk("rx_dn_read_pre", dn_read, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rx_dn_read", dn_read, 0);
    chk("rx_busy", {i_busy, d_busy}, 2'b10);
    chk("rx_i_rdata", i_rdata, 0);
    i_read = 1'b0;
    #1;
    chk("rx_busy_drop", i_busy, 0);
    step();
    reset    = 1'b0;
    dn_ack   = 1'b1;
    dn_rdata = 32'hCAFEF00D;
    #1;
    chk("rx_late_dn_read", dn_read, 0);
    step();
    dn_ack = 1'b0;
    #1;
    chk("rx_late_rdata", i_rdata, 0);
    chk("rx_late_dn", {dn_read, dn_write}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-port arbiter that shares the single main-memory (data_memory) port between the instruction-side requester (I-port, read-only) and the data cache (D-port, read/write).
- Each upstream port uses the cache miss/write-through handshake: request held as a level, busy high until completion, completion signalled by exactly one busy-low cycle.
- Downstream, it issues one transaction at a time and waits for a single-cycle ack from memory.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_addr  in  ADDR_WIDTH  I-port address
i_read  in  1  I-port read request (level)
i_rdata  out  DATA_WIDTH  I-port read data, valid in the completion cycle
i_busy  out  1  I-port busy
d_addr  in  ADDR_WIDTH  D-port address
d_wdata  in  DATA_WIDTH  D-port write data
d_read  in  1  D-port read request (level)
d_write  in  1  D-port write request (level)
d_rdata  out  DATA_WIDTH  D-port read data, valid in the completion cycle
d_busy  out  1  D-port busy
dn_addr  out  ADDR_WIDTH  memory address
dn_wdata  out  DATA_WIDTH  memory write data
dn_read  out  1  memory read strobe (level)
dn_write  out  1  memory write strobe (level)
dn_rdata  in  DATA_WIDTH  memory read data, valid when dn_ack=1
dn_ack  in  1  memory completion, single-cycle pulse
owner  out  1  current or last grant: 0=I, 1=D (debug)

Behaviour:
- Reset values: state IDLE; all dn_* = 0; i_rdata = d_rdata = 0; owner = 0; rr pointer = 0 (I preferred first). Because reset is asynchronous, dn_read/dn_write drop immediately, even mid-transaction.
- Busy rule: x_busy = x_req && !(state==DONE && owner==x), where i_req = i_read and d_req = d_read|d_write.
  - Combinational, so busy is high in the very first cycle a request appears.
  - No request gives busy=0.
- States: IDLE, XFER, DONE.
- IDLE:
  - If any request is present, grant one, latch addr, wdata and op, set owner, and go to XFER.
  - Latched values drive dn_* from the next cycle and stay stable for the whole transaction.
  - Without a request, remain in IDLE.
- XFER:
  - dn_read or dn_write is held high.
  - On dn_ack: register dn_rdata into the owner's rdata output (reads only) and go to DONE.
- DONE (one cycle): dn_* = 0; owner's busy = 0; owner's rdata valid. Next state is IDLE unconditionally.
  - The requester still asserts its request in this cycle; that must not be re-granted.
- Latency: request at cycle 0, dn strobe at cycles 1..k, ack at cycle k, busy low at cycle k+1. Minimum 3 cycles with a zero-wait memory (ack in cycle 1).
- Arbitration with both requesting in IDLE: see Optional Feature.
- d_read and d_write both high: treated as a write.
- Request withdrawn during XFER:
  - The transaction still completes downstream.
  - DONE still occurs, but busy stays 0 because the request is gone.
  - Read data is still written to the rdata register.
- dn_ack outside XFER: ignored.
- rdata registers hold their value between transactions. Write transactions do not modify rdata.
- Back-to-back: a new request in the cycle after DONE is granted in that IDLE cycle. This covers a cache write-miss (read fill then write-through) with no extra gap.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Round robin. A 1-bit pointer favours the port that did not win the previous grant.
  - The pointer updates on every grant.
  - Neither port can be starved for more than one transaction.
- Undefined:
  - Fixed priority, D-port over I-port.
  - The pointer logic is absent.
  - The I-port can be starved while the D-port keeps requesting.

Test Plan:
- Single read: i_read=1, i_addr=0x40, memory returns 0xDEADBEEF with ack at cycle 3 -> dn_read high cycles 1-3 with dn_addr=0x40, i_busy=1 cycles 0-3, i_busy=0 and i_rdata=0xDEADBEEF at cycle 4, dn_* = 0 at cycle 4.
- Write: d_write=1, d_addr=0x100, d_wdata=0x12345678, ack after 2 cycles -> dn_write=1 with the latched addr/data held until ack, d_busy low exactly one cycle, d_rdata unchanged.
- Contention: i_read and d_read asserted together and held, 4 transactions.
  - With ARB_ROUND_ROBIN_EN: grant order I, D, I, D.
  - Without it: D wins every time and i_busy stays 1.
- Back-to-back write miss: d_read to 0x200 (data 0xA5A5A5A5), then d_write 0x200 in the cycle after DONE -> second grant in that cycle, dn_write asserted the following cycle.
- Withdrawal: d_read dropped during XFER -> dn_read is held until ack, d_busy stays 0 throughout DONE, and the next request is served normally.
- Reset mid-XFER: assert reset with dn_read=1 -> dn_read=0, i_busy/d_busy follow only the request lines, state IDLE; a late dn_ack after reset is ignored.
